// File: rtl/psram_qpi_responder.sv
// Device-side responder for the LY68S3200 serial PSRAM QPI lane.
// Decodes a serial command (0x35 QPI enable, 0x38 quad write, 0xEB quad read),
// a six-nibble quad address and one data byte. Read data is returned after
// WAITCYCLES turnaround cycles. Array contents are never reset.
// Optional build macro: PSRAM_RESP_QPI_CHECK_EN rejects quad commands until QPI is enabled.
module psram_qpi_responder #(
  parameter int unsigned AW         = 10,
  parameter int unsigned WAITCYCLES = 6
) (
  input  logic        reset,
  input  logic        i_clkRAM,
  input  logic        i_psram_cs,
  inout  wire         io_psram_data0,
  inout  wire         io_psram_data1,
  inout  wire         io_psram_data2,
  inout  wire         io_psram_data3,
  output logic        o_qpi_mode,
  output logic        o_cmd_error,
  output logic [15:0] o_wr_count,
  output logic [15:0] o_rd_count
);

  // Wide enough to hold k up to 15+WAITCYCLES.
  localparam int unsigned CntW = $clog2(WAITCYCLES + 17);
  localparam logic [CntW-1:0] KCmdLast  = CntW'(7);
  localparam logic [CntW-1:0] KAddrLast = CntW'(13);
  localparam logic [CntW-1:0] KWdataHi  = CntW'(14);
  localparam logic [CntW-1:0] KWaitLast = CntW'(13 + WAITCYCLES);
  localparam logic [CntW-1:0] KRdLo     = CntW'(15 + WAITCYCLES);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StWdata, StWait, StRdata, StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [6:0]      cmd_q, cmd_d;
  logic            is_write_q, is_write_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      wdata_hi_q, wdata_hi_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            qpi_q, qpi_d;
  logic            err_q, err_d;
  logic [15:0]     wr_cnt_q, wr_cnt_d;
  logic [15:0]     rd_cnt_q, rd_cnt_d;

  logic [7:0]      mem [2**AW];
  logic            mem_we;
  logic [3:0]      nib_in;
  logic [7:0]      cmd_next;
  logic [AW-1:0]   addr_next;
  logic            quad_ok;
  logic            drive_en;
  logic [3:0]      drive_nib;

  assign nib_in    = {io_psram_data3, io_psram_data2, io_psram_data1, io_psram_data0};
  assign cmd_next  = {cmd_q, io_psram_data0};
  // Upper address bits fall off the top, so addresses alias modulo 2^AW.
  assign addr_next = AW'({addr_q, nib_in});

`ifdef PSRAM_RESP_QPI_CHECK_EN
  assign quad_ok = qpi_q;
`else
  assign quad_ok = 1'b1;
`endif

  // State register and datapath registers.
  always_ff @(posedge i_clkRAM or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cmd_q      <= '0;
      is_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_hi_q <= '0;
      rd_data_q  <= '0;
      qpi_q      <= 1'b0;
      err_q      <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_hi_q <= wdata_hi_d;
      rd_data_q  <= rd_data_d;
      qpi_q      <= qpi_d;
      err_q      <= err_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
    end
  end

  // Byte array write port; contents deliberately survive reset.
  always_ff @(posedge i_clkRAM) begin
    if (mem_we) begin
      mem[addr_q] <= {wdata_hi_q, nib_in};
    end
  end

  // Next-state and datapath update, one step per sampled edge while CS is low.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_hi_d = wdata_hi_q;
    rd_data_d  = rd_data_q;
    qpi_d      = qpi_q;
    err_d      = 1'b0;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    mem_we     = 1'b0;
    if (i_psram_cs) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      if (state_q != StDone) begin
        cnt_d = cnt_q + CntW'(1);
      end
      unique case (state_q)
        StIdle, StCmd: begin
          cmd_d   = cmd_next[6:0];
          state_d = StCmd;
          if (cnt_q == KCmdLast) begin
            state_d = StDone;
            case (cmd_next)
              8'h35: qpi_d = 1'b1;
              8'h38: begin
                if (quad_ok) begin
                  state_d    = StAddr;
                  is_write_d = 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end
              8'hEB: begin
                if (quad_ok) begin
                  state_d    = StAddr;
                  is_write_d = 1'b0;
                end else begin
                  err_d = 1'b1;
                end
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        StAddr: begin
          addr_d = addr_next;
          if (cnt_q == KAddrLast) begin
            if (is_write_q) begin
              state_d = StWdata;
            end else begin
              // Read data is captured here, so a write committed earlier is visible.
              rd_data_d = mem[addr_next];
              state_d   = (WAITCYCLES == 0) ? StRdata : StWait;
            end
          end
        end
        StWdata: begin
          if (cnt_q == KWdataHi) begin
            wdata_hi_d = nib_in;
          end else begin
            mem_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + 16'd1;
            state_d  = StDone;
          end
        end
        StWait: begin
          if (cnt_q == KWaitLast) begin
            state_d = StRdata;
          end
        end
        StRdata: begin
          if (cnt_q == KRdLo) begin
            rd_cnt_d = rd_cnt_q + 16'd1;
            state_d  = StDone;
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Pin drive: only in RDATA, and released the instant CS rises.
  always_comb begin
    drive_en  = (state_q == StRdata) && !i_psram_cs;
    drive_nib = (cnt_q == KRdLo) ? rd_data_q[3:0] : rd_data_q[7:4];
  end

  assign io_psram_data0 = drive_en ? drive_nib[0] : 1'bz;
  assign io_psram_data1 = drive_en ? drive_nib[1] : 1'bz;
  assign io_psram_data2 = drive_en ? drive_nib[2] : 1'bz;
  assign io_psram_data3 = drive_en ? drive_nib[3] : 1'bz;

  assign o_qpi_mode  = qpi_q;
  assign o_cmd_error = err_q;
  assign o_wr_count  = wr_cnt_q;
  assign o_rd_count  = rd_cnt_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Scoreboard bench for psram_qpi_responder: stimulus pushes expected values,
// a monitor samples pins/outputs 2ns after each falling clock edge and compares.
// Released pins are pulled up, so high-Z reads back as 4'hF.
module tb_psram_qpi_responder;

  localparam int unsigned W = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0;
  logic        tb_en = 1'b0;
  logic [3:0]  tb_nib = 4'h0;
  wire         pad0, pad1, pad2, pad3;
  logic        qpi_mode, cmd_error;
  logic [15:0] wr_count, rd_count;

  pullup (pad0);
  pullup (pad1);
  pullup (pad2);
  pullup (pad3);

  assign pad0 = tb_en ? tb_nib[0] : 1'bz;
  assign pad1 = tb_en ? tb_nib[1] : 1'bz;
  assign pad2 = tb_en ? tb_nib[2] : 1'bz;
  assign pad3 = tb_en ? tb_nib[3] : 1'bz;

  psram_qpi_responder #(
    .AW         (10),
    .WAITCYCLES (W)
  ) dut (
    .reset          (rst_n),
    .i_clkRAM       (clk),
    .i_psram_cs     (cs),
    .io_psram_data0 (pad0),
    .io_psram_data1 (pad1),
    .io_psram_data2 (pad2),
    .io_psram_data3 (pad3),
    .o_qpi_mode     (qpi_mode),
    .o_cmd_error    (cmd_error),
    .o_wr_count     (wr_count),
    .o_rd_count     (rd_count)
  );

  always #5 clk = ~clk;

  localparam int SelPins = 0;
  localparam int SelWr   = 1;
  localparam int SelRd   = 2;
  localparam int SelQpi  = 3;
  localparam int SelErr  = 4;

  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_val(input int sel, input logic [15:0] v, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = v;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // Monitor: drain everything queued for this cycle, sampled mid-low-phase.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      #2;
      while (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        case (e.sel)
          SelPins: act = {12'h000, pad3, pad2, pad1, pad0};
          SelWr:   act = wr_count;
          SelRd:   act = rd_count;
          SelQpi:  act = {15'h0000, qpi_mode};
          default: act = {15'h0000, cmd_error};
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  // One clock of stimulus, applied just after the falling edge.
  task automatic tick(input logic c, input logic en, input logic [3:0] n);
    @(negedge clk);
    cs     = c;
    tb_en  = en;
    tb_nib = n;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) tick(1'b0, 1'b1, {3'b000, c[i]});
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) tick(1'b0, 1'b1, a[i*4 +: 4]);
  endtask

  task automatic cs_high();
    tick(1'b1, 1'b0, 4'h0);
    expect_val(SelPins, 16'h000F, "release_hiz");
  endtask

  task automatic write_byte(input logic [23:0] a, input logic [7:0] d);
    send_cmd(8'h38);
    send_addr(a);
    tick(1'b0, 1'b1, d[7:4]);
    tick(1'b0, 1'b1, d[3:0]);
    cs_high();
  endtask

  task automatic read_byte(input logic [23:0] a, input logic [7:0] d);
    send_cmd(8'hEB);
    send_addr(a);
    for (int i = 0; i < int'(W); i++) begin
      tick(1'b0, 1'b0, 4'h0);
      expect_val(SelPins, 16'h000F, "wait_hiz");
    end
    tick(1'b0, 1'b0, 4'h0);
    expect_val(SelPins, {12'h000, d[7:4]}, "rd_hi_nibble");
    tick(1'b0, 1'b0, 4'h0);
    expect_val(SelPins, {12'h000, d[3:0]}, "rd_lo_nibble");
    cs_high();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset held with CS low and the lane toggling.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 4'(i * 5));
    expect_val(SelWr, 16'h0000, "reset_wr_count");
    expect_val(SelRd, 16'h0000, "reset_rd_count");
    expect_val(SelQpi, 16'h0000, "reset_qpi");
    expect_val(SelErr, 16'h0000, "reset_err");
    tick(1'b0, 1'b0, 4'h0);
    expect_val(SelPins, 16'h000F, "reset_hiz");
    tick(1'b1, 1'b0, 4'h0);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 4'h0);

    // QPI enable.
    send_cmd(8'h35);
    tick(1'b0, 1'b0, 4'h0);
    expect_val(SelQpi, 16'h0001, "qpi_set");
    expect_val(SelErr, 16'h0000, "qpi_no_err");
    expect_val(SelPins, 16'h000F, "qpi_hiz");
    cs_high();

    // Write then read back.
    write_byte(24'h000123, 8'hA5);
    read_byte(24'h000123, 8'hA5);
    expect_val(SelWr, 16'h0001, "wr_count_1");
    expect_val(SelRd, 16'h0001, "rd_count_1");

    // Aborted write after the high nibble leaves the prefill intact.
    write_byte(24'h000010, 8'h77);
    send_cmd(8'h38);
    send_addr(24'h000010);
    tick(1'b0, 1'b1, 4'h3);
    cs_high();
    expect_val(SelWr, 16'h0002, "abort_wr_count");
    read_byte(24'h000010, 8'h77);
    expect_val(SelRd, 16'h0002, "rd_count_2");

    // Read aborted after its high nibble: pins release with CS, count unchanged.
    send_cmd(8'hEB);
    send_addr(24'h000123);
    for (int i = 0; i < int'(W); i++) tick(1'b0, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 4'h0);
    expect_val(SelPins, 16'h000A, "abort_rd_hi");
    cs_high();
    tick(1'b1, 1'b0, 4'h0);
    expect_val(SelRd, 16'h0002, "abort_rd_count");

    // Unknown command: exactly one cycle of error, no drive.
    send_cmd(8'h12);
    tick(1'b0, 1'b0, 4'h0);
    expect_val(SelErr, 16'h0001, "unk_err_pulse");
    expect_val(SelPins, 16'h000F, "unk_hiz");
    tick(1'b0, 1'b0, 4'h0);
    expect_val(SelErr, 16'h0000, "unk_err_end");
    cs_high();

    // Address alias with AW=10.
    write_byte(24'h000400, 8'h5A);
    read_byte(24'h000000, 8'h5A);
    expect_val(SelWr, 16'h0003, "wr_count_3");
    expect_val(SelRd, 16'h0003, "rd_count_3");

    // Reset during a write with only the high nibble received.
    send_cmd(8'h38);
    send_addr(24'h000010);
    tick(1'b0, 1'b1, 4'h1);
    tick(1'b0, 1'b1, 4'h2);
    rst_n = 1'b0;
    expect_val(SelQpi, 16'h0000, "midreset_qpi");
    expect_val(SelWr, 16'h0000, "midreset_wr_count");
    tick(1'b1, 1'b0, 4'h0);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 4'h0);

`ifdef PSRAM_RESP_QPI_CHECK_EN
    // Quad read before QPI enable is rejected.
    send_cmd(8'hEB);
    tick(1'b0, 1'b0, 4'h0);
    expect_val(SelErr, 16'h0001, "gate_err_pulse");
    expect_val(SelPins, 16'h000F, "gate_hiz");
    for (int k = 9; k <= 21; k++) begin
      tick(1'b0, 1'b0, 4'h0);
      expect_val(SelPins, 16'h000F, "gate_hiz");
    end
    cs_high();
    expect_val(SelRd, 16'h0000, "gate_rd_count");
`else
    // Array survives reset and the partial write was discarded.
    read_byte(24'h000010, 8'h77);
    expect_val(SelRd, 16'h0001, "post_reset_rd_count");
    read_byte(24'h000000, 8'h5A);
    expect_val(SelRd, 16'h0002, "post_reset_rd_count_2");
`endif

    tick(1'b1, 1'b0, 4'h0);
    tick(1'b1, 1'b0, 4'h0);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
